dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/rv32i_arb_pkg.sv | 32 +++
 rtl/dmem_arbiter_if.sv | 51 +++++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the lock FSM states, burst counter width and default burst limit.
package rv32i_arb_pkg;

   localparam int unsigned MAX_BURST_DEF = 4;
   localparam int unsigned CNT_W         = 4;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [31:0]      word_t;
   typedef logic [3:0]       be_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   // Arbitration result: valid = some port wins, port = which one.
   typedef struct packed {
      logic valid;
      logic port;
   } win_t;

   function automatic state_t lock_of(input logic p);
      return p ? LOCK1 : LOCK0;
   endfunction

   function automatic cnt_t sat_inc(input cnt_t c);
      return (c == '1) ? c : c + cnt_t'(1);
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the data memory.
// slave: arbiter side; master: requesters plus memory (environment side).
interface dmem_arbiter_if;
   import rv32i_arb_pkg::*;

   logic  m0_req;
   logic  m0_we;
   be_t   m0_be;
   word_t m0_addr;
   word_t m0_wdata;
   logic  m0_gnt;
   logic  m0_rvalid;

   logic  m1_req;
   logic  m1_we;
   be_t   m1_be;
   word_t m1_addr;
   word_t m1_wdata;
   logic  m1_gnt;
   logic  m1_rvalid;

   word_t rdata;

   logic  mem_en;
   logic  mem_we;
   be_t   mem_be;
   word_t mem_addr;
   word_t mem_wdata;
   word_t mem_rdata;

   modport slave (
      input  m0_req, m0_we, m0_be, m0_addr, m0_wdata,
      output m0_gnt, m0_rvalid,
      input  m1_req, m1_we, m1_be, m1_addr, m1_wdata,
      output m1_gnt, m1_rvalid,
      output rdata,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output m0_req, m0_we, m0_be, m0_addr, m0_wdata,
      input  m0_gnt, m0_rvalid,
      output m1_req, m1_we, m1_be, m1_addr, m1_wdata,
      input  m1_gnt, m1_rvalid,
      input  rdata,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: zero-cycle grant, burst-limited locking.
// Ports: clk, reset (sync, active-high), bus (dmem_arbiter_if.slave).
module dmem_arbiter
   import rv32i_arb_pkg::*;
#(
   parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
   input  logic          clk,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);

   localparam cnt_t LIMIT = cnt_t'(MAX_BURST);

   state_t state;
   logic   last_owner;
   cnt_t   burst_cnt;
   logic   rv0_q;
   logic   rv1_q;

   win_t   win;
   logic   gnt0;
   logic   gnt1;

   function automatic win_t pick(
      input state_t st,
      input logic   lo,
      input cnt_t   cnt,
      input logic   r0,
      input logic   r1
   );
      win_t w;
      w = '0;
      unique case (st)
         LOCK0: begin
            if (r0 && (!r1 || cnt < LIMIT))
               w = '{valid: 1'b1, port: 1'b0};
            else if (r1)
               w = '{valid: 1'b1, port: 1'b1};
         end
         LOCK1: begin
            if (r1 && (!r0 || cnt < LIMIT))
               w = '{valid: 1'b1, port: 1'b1};
            else if (r0)
               w = '{valid: 1'b1, port: 1'b0};
         end
         default: begin
            // Contention from idle goes to whoever did not own last.
            if (r0 && r1)
               w = '{valid: 1'b1, port: ~lo};
            else if (r0 || r1)
               w = '{valid: 1'b1, port: r1};
         end
      endcase
      return w;
   endfunction

   always_comb begin
      win = pick(state, last_owner, burst_cnt,
                 bus.m0_req, bus.m1_req);
      if (reset)
         win = '0;
   end

   assign gnt0 = win.valid & ~win.port;
   assign gnt1 = win.valid &  win.port;

   always_comb begin
      bus.mem_we    = 1'b0;
      bus.mem_be    = '0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      unique case (1'b1)
         gnt0: begin
            bus.mem_we    = bus.m0_we;
            bus.mem_be    = bus.m0_be;
            bus.mem_addr  = bus.m0_addr;
            bus.mem_wdata = bus.m0_wdata;
         end
         gnt1: begin
            bus.mem_we    = bus.m1_we;
            bus.mem_be    = bus.m1_be;
            bus.mem_addr  = bus.m1_addr;
            bus.mem_wdata = bus.m1_wdata;
         end
         default: ;
      endcase
   end

   assign bus.m0_gnt = gnt0;
   assign bus.m1_gnt = gnt1;
   assign bus.mem_en = gnt0 | gnt1;

   // Gating with reset drops a read granted just before reset rose.
   assign bus.m0_rvalid = rv0_q & ~reset;
   assign bus.m1_rvalid = rv1_q & ~reset;
   assign bus.rdata     = bus.mem_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         burst_cnt  <= '0;
         rv0_q      <= 1'b0;
         rv1_q      <= 1'b0;
      end else begin
         rv0_q <= gnt0 & ~bus.m0_we;
         rv1_q <= gnt1 & ~bus.m1_we;
         if (win.valid) begin
            state      <= lock_of(win.port);
            last_owner <= win.port;
            if (state == lock_of(win.port))
               burst_cnt <= sat_inc(burst_cnt);
            else
               burst_cnt <= cnt_t'(1);
         end else begin
            state     <= IDLE;
            burst_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed per-cycle vectors.
// Expected grants/reads are queued by the driver, checked by a monitor.
module tb_dmem_arbiter;

   localparam int NONE = -1;

   typedef struct {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } preq_t;

   typedef struct {
      int          cyc;
      logic        port;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } gexp_t;

   typedef struct {
      int          cyc;
      logic        port;
      logic [31:0] data;
   } rexp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   n_chk;
   int   n_fail;

   gexp_t gq[$];
   rexp_t rq[$];

   dmem_arbiter_if bus ();

   dmem_arbiter #(.MAX_BURST(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Memory model: read data one cycle after the address.
   always @(posedge clk) bus.mem_rdata <= mem_f(bus.mem_addr);

   function automatic preq_t nop();
      preq_t p;
      p.req = 1'b0; p.we = 1'b0; p.be = '0;
      p.addr = '0; p.wdata = '0;
      return p;
   endfunction

   function automatic preq_t rd(input logic [31:0] a);
      preq_t p;
      p.req = 1'b1; p.we = 1'b0; p.be = 4'hF;
      p.addr = a; p.wdata = '0;
      return p;
   endfunction

   function automatic preq_t wr(input logic [31:0] a,
                                input logic [3:0]  b,
                                input logic [31:0] d);
      preq_t p;
      p.req = 1'b1; p.we = 1'b1; p.be = b;
      p.addr = a; p.wdata = d;
      return p;
   endfunction

   task automatic chk(input string name,
                      input logic [127:0] act,
                      input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic p, input preq_t r, input bit kill);
      gexp_t g;
      rexp_t e;
      g.cyc = cyc; g.port = p; g.we = r.we; g.be = r.be;
      g.addr = r.addr; g.wdata = r.wdata;
      gq.push_back(g);
      if (!r.we && !kill) begin
         e.cyc = cyc + 1; e.port = p; e.data = mem_f(r.addr);
         rq.push_back(e);
      end
   endtask

   // One cycle of stimulus; exp is the hand-computed winner.
   task automatic step(input bit rst, input preq_t p0,
                       input preq_t p1, input int exp,
                       input bit kill = 1'b0);
      @(posedge clk);
      #1;
      reset        = rst;
      bus.m0_req   = p0.req;
      bus.m0_we    = p0.we;
      bus.m0_be    = p0.be;
      bus.m0_addr  = p0.addr;
      bus.m0_wdata = p0.wdata;
      bus.m1_req   = p1.req;
      bus.m1_we    = p1.we;
      bus.m1_be    = p1.be;
      bus.m1_addr  = p1.addr;
      bus.m1_wdata = p1.wdata;
      if (exp == 0) push(1'b0, p0, kill);
      else if (exp == 1) push(1'b1, p1, kill);
   endtask

   task automatic mon();
      logic  g0, g1, v0, v1;
      gexp_t g;
      rexp_t r;
      g0 = bus.m0_gnt;    g1 = bus.m1_gnt;
      v0 = bus.m0_rvalid; v1 = bus.m1_rvalid;
      if (reset)
         chk("reset_outputs", {g0, g1, bus.mem_en, v0, v1}, '0);
      chk("gnt_onehot", g0 & g1, '0);
      chk("mem_en", bus.mem_en, g0 | g1);
      chk("rvalid_onehot", v0 & v1, '0);
      if (!bus.mem_en)
         chk("mem_idle_zero", {bus.mem_we, bus.mem_be,
                               bus.mem_addr, bus.mem_wdata}, '0);
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
         chk("missed_gnt", cyc, gq[0].cyc);
         gq.delete(0);
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
         chk("missed_rvalid", cyc, rq[0].cyc);
         rq.delete(0);
      end
      if (g0 | g1) begin
         if (gq.size() == 0 || gq[0].cyc != cyc) begin
            chk("unexpected_gnt", {g0, g1}, '0);
         end else begin
            g = gq.pop_front();
            chk("gnt_port", g1, g.port);
            chk("mem_fields",
                {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata},
                {g.we, g.be, g.addr, g.wdata});
         end
      end
      if (v0 | v1) begin
         if (rq.size() == 0 || rq[0].cyc != cyc) begin
            chk("unexpected_rvalid", {v0, v1}, '0);
         end else begin
            r = rq.pop_front();
            chk("rvalid_port", v1, r.port);
            chk("rdata", bus.rdata, r.data);
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         mon();
      end
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset  = 1'b1;
      bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_be = '0;
      bus.m0_addr = '0;  bus.m0_wdata = '0;
      bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_be = '0;
      bus.m1_addr = '0;  bus.m1_wdata = '0;

      // Reset holds off grants even with both requesting.
      repeat (3) step(1, rd(32'h10), rd(32'h20), NONE);

      // Lone m0 read.
      step(0, rd(32'h0000_0100), nop(), 0);
      step(0, nop(), nop(), NONE);

      // m1 partial write, no rvalid.
      step(0, nop(), wr(32'h200, 4'b0011, 32'hDEAD_BEEF), 1);
      step(0, nop(), nop(), NONE);

      // Continuous contention: bursts of four per port.
      step(0, rd(32'h1000), rd(32'h2000), 0);
      step(0, rd(32'h1000), rd(32'h2000), 0);
      step(0, rd(32'h1000), rd(32'h2000), 0);
      step(0, rd(32'h1000), rd(32'h2000), 0);
      step(0, rd(32'h1000), rd(32'h2000), 1);
      step(0, rd(32'h1000), rd(32'h2000), 1);
      step(0, rd(32'h1000), rd(32'h2000), 1);
      step(0, rd(32'h1000), rd(32'h2000), 1);
      step(0, rd(32'h1000), rd(32'h2000), 0);
      step(0, rd(32'h1000), rd(32'h2000), 0);

      // m0 drops at count 2: m1 takes over with a fresh count.
      step(0, nop(), rd(32'h2000), 1);
      step(0, rd(32'h1000), rd(32'h2004), 1);
      step(0, rd(32'h1000), rd(32'h2008), 1);
      step(0, rd(32'h1000), rd(32'h200C), 1);
      step(0, rd(32'h1000), rd(32'h2010), 0);
      step(0, nop(), nop(), NONE);

      // Alternating single reads, no bubbles.
      step(0, rd(32'h3000), nop(), 0);
      step(0, nop(), rd(32'h3100), 1);
      step(0, rd(32'h3004), nop(), 0);
      step(0, nop(), rd(32'h3104), 1);
      step(0, rd(32'h3008), nop(), 0);
      step(0, nop(), rd(32'h3108), 1);
      step(0, nop(), nop(), NONE);

      // Uncontended m0 runs past the limit; counter saturates.
      for (int i = 0; i < 16; i++)
         step(0, rd(32'h4000 + 32'(4 * i)), nop(), 0);
      step(0, rd(32'h4100), rd(32'h5000), 1);
      step(0, nop(), nop(), NONE);

      // Reset right after a read grant discards its rvalid.
      step(0, rd(32'h300), nop(), 0, 1'b1);
      step(1, rd(32'h304), rd(32'h404), NONE);
      step(1, rd(32'h304), rd(32'h404), NONE);
      step(0, rd(32'h304), rd(32'h404), 0);
      step(0, rd(32'h308), rd(32'h404), 0);
      step(0, nop(), nop(), NONE);
      step(0, nop(), nop(), NONE);

      @(negedge clk);
      @(negedge clk);
      chk("gnt_queue_empty", gq.size(), 0);
      chk("rvalid_queue_empty", rq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
